ram_arbiter: RTL

// - Shares the single-port word RAM (32-bit words, combinational read while
//   mem_read=1, write on posedge clk) between two requesters:
//   M0 = CPU load/store port, M1 = boot loader / debug port.
// - Adds byte-strobe writes on top of the word-only RAM by sequencing a

---
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port word RAM between M0 (CPU) and M1 (boot/debug),
// adding byte-strobe writes via read-modify-write.
// Ports: clk, rst_n (sync, active-low);
//        mN_req/we/addr/wdata/wstrb in, mN_gnt/ack/rdata out (N=0,1);
//        ram_addr/read/write/wdata out, ram_rdata in.
// Option: define ARB_ROUND_ROBIN_EN for round-robin on conflicts, else M0 has fixed priority.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        lat_owner;
    logic [31:0] merge_q;
    logic [31:0] merged;

    logic        sel_m1;
    logic        take;
    logic        partial;
    logic        done;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_owner;

    // On conflict the master that did not own the last grant wins.
    assign sel_m1 = m1_req & (~m0_req | ~last_owner);
`else
    assign sel_m1 = m1_req & ~m0_req;
`endif

    // Grants only in IDLE and never while reset is held.
    assign take   = (state == S_IDLE) & (m0_req | m1_req) & rst_n;
    assign m0_gnt = take & ~sel_m1;
    assign m1_gnt = take & sel_m1;

    assign partial = lat_we & (lat_wstrb != 4'hF) & (lat_wstrb != 4'h0);

    // Completion: every ACCESS except the partial-write read phase, or WRITE.
    assign done = ((state == S_ACCESS) & ~partial) | (state == S_WRITE);

    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (lat_wstrb[i]) begin
                merged[8*i +: 8] = lat_wdata[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (take) state_nx = S_ACCESS;
            S_ACCESS: state_nx = partial ? S_WRITE : S_IDLE;
            S_WRITE:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // RAM-side outputs; strobes are gated with rst_n so a reset in
    // ACCESS/WRITE can never commit a half-finished write.
    always_comb begin
        ram_addr  = 32'h0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_wdata = 32'h0;
        case (state)
            S_ACCESS: begin
                ram_addr = lat_addr;
                if (!lat_we || partial) begin
                    ram_read = rst_n;
                end else if (lat_wstrb == 4'hF) begin
                    ram_write = rst_n;
                    ram_wdata = lat_wdata;
                end
            end
            S_WRITE: begin
                ram_addr  = lat_addr;
                ram_write = rst_n;
                ram_wdata = merge_q;
            end
            default: ;
        endcase
    end

    // Request latches, merge register, acks and read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_wstrb  <= 4'h0;
            lat_owner  <= 1'b0;
            merge_q    <= 32'h0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= 32'h0;
            m1_rdata   <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            m0_ack <= done & ~lat_owner;
            m1_ack <= done & lat_owner;
            if (take) begin
                lat_owner <= sel_m1;
`ifdef ARB_ROUND_ROBIN_EN
                last_owner <= sel_m1;
`endif
                if (sel_m1) begin
                    lat_we    <= m1_we;
                    lat_addr  <= m1_addr;
                    lat_wdata <= m1_wdata;
                    lat_wstrb <= m1_wstrb;
                end else begin
                    lat_we    <= m0_we;
                    lat_addr  <= m0_addr;
                    lat_wdata <= m0_wdata;
                    lat_wstrb <= m0_wstrb;
                end
            end
            if (state == S_ACCESS) begin
                if (!lat_we) begin
                    if (lat_owner) begin
                        m1_rdata <= ram_rdata;
                    end else begin
                        m0_rdata <= ram_rdata;
                    end
                end else if (partial) begin
                    merge_q <= merged;
                end
            end
        end
    end

endmodule
